// File: rtl/jedro_1_arb_pkg.sv
// Shared types and defaults for the jedro_1 unified-memory arbiter.
// Tracks which port owns the read response that returns one cycle after a grant.
package jedro_1_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } arb_owner_e;

    localparam int unsigned ARB_ADDR_WIDTH   = 32;
    localparam int unsigned ARB_DATA_WIDTH   = 32;
    localparam int unsigned ARB_STARVE_LIMIT = 4;

    function automatic int unsigned starve_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/jedro_1_starve_cnt.sv
// Saturating counter of consecutive fetch denials.
// sat_o is high once LIMIT denials have been seen, which forces the next fetch grant.
module jedro_1_starve_cnt
    import jedro_1_arb_pkg::*;
#(
    parameter int unsigned LIMIT = ARB_STARVE_LIMIT
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned W = starve_width(LIMIT);
    localparam logic [W-1:0] LIMIT_VAL = W'(LIMIT);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == LIMIT_VAL);

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Shares one single-port byte-write RAM between the jedro_1 fetch and LSU ports.
// Data has fixed priority; fetch is forced through after STARVE_LIMIT consecutive denials.
module jedro_1_mem_arbiter
    import jedro_1_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    ram_en_o,
    output logic [DATA_WIDTH/8-1:0] ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic       starve_sat;
    logic       starve_inc;
    logic       instr_gnt;
    logic       data_gnt;
    arb_owner_e owner_d;
    arb_owner_e owner_q;

    always_comb begin
        instr_gnt = instr_req_i && (!data_req_i || starve_sat);
        data_gnt  = data_req_i && !instr_gnt;
    end

    // A denial only accumulates while fetch keeps asking; any grant or idle cycle resets it.
    assign starve_inc = instr_req_i && !instr_gnt;

    jedro_1_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_i  (starve_inc),
        .clr_i  (!starve_inc),
        .sat_o  (starve_sat)
    );

    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (instr_gnt) begin
            ram_en_o   = 1'b1;
            ram_addr_o = instr_addr_i;
        end else if (data_gnt) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = data_addr_i;
            ram_wdata_o = data_wdata_i;
            ram_we_o    = data_we_i ? data_be_i : {BE_WIDTH{1'b0}};
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (instr_gnt) begin
            owner_d = OWN_INSTR;
        end else if (data_gnt && !data_we_i) begin
            owner_d = OWN_DATA;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign instr_gnt_o    = instr_gnt;
    assign data_gnt_o     = data_gnt;
    assign instr_rvalid_o = (owner_q == OWN_INSTR);
    assign data_rvalid_o  = (owner_q == OWN_DATA);
    assign instr_rdata_o  = ram_rdata_i;
    assign data_rdata_o   = ram_rdata_i;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Scoreboard bench for jedro_1_mem_arbiter with a behavioural RAM and reference memory.
// Grants are predicted from the priority/starvation rules; read data is popped by a separate monitor.
module tb_jedro_1_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        instr_gnt, instr_rvalid;
    logic [31:0] instr_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;

    int total = 0;
    int bad = 0;
    int cycle = 0;

    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] iq [$];
    logic [31:0] dq [$];
    bit          exp_ig = 1'b0;
    bit          exp_dg = 1'b0;
    int          denials = 0;
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;
    int          i_cnt = 0;
    int          d_cnt = 0;
    int          i_cyc = 0;
    int          d_cyc = 0;

    always #5 clk = ~clk;

    jedro_1_mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .instr_req_i    (i_req),
        .instr_addr_i   (i_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (d_req),
        .data_we_i      (d_we),
        .data_be_i      (d_be),
        .data_addr_i    (d_addr),
        .data_wdata_i   (d_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Single-port RAM with one-cycle read latency and byte-enable writes.
    always @(posedge clk) begin
        cycle++;
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= ram_mem[ram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reference model: predict grants and ram signals, push expected read data.
    always @(negedge clk) begin
        if (!rstn) begin
            denials = 0;
            exp_ig  = 1'b0;
            exp_dg  = 1'b0;
        end else begin
            exp_ig = i_req && (!d_req || denials >= LIMIT);
            exp_dg = d_req && !exp_ig;
            check_output("instr_gnt", 32'(instr_gnt), 32'(exp_ig));
            check_output("data_gnt", 32'(data_gnt), 32'(exp_dg));
            check_output("ram_en", 32'(ram_en), 32'(exp_ig | exp_dg));
            if (exp_ig) begin
                check_output("ram_addr_instr", ram_addr, i_addr);
                check_output("ram_we_instr", 32'(ram_we), 32'd0);
                iq.push_back(ref_mem[i_addr[9:2]]);
            end else if (exp_dg) begin
                check_output("ram_addr_data", ram_addr, d_addr);
                if (d_we) begin
                    check_output("ram_we_write", 32'(ram_we), 32'(d_be));
                    check_output("ram_wdata", ram_wdata, d_wdata);
                    for (int b = 0; b < 4; b++) begin
                        if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
                    end
                end else begin
                    check_output("ram_we_read", 32'(ram_we), 32'd0);
                    dq.push_back(ref_mem[d_addr[9:2]]);
                end
            end else begin
                check_output("idle_ram_we", 32'(ram_we), 32'd0);
                check_output("idle_ram_addr", ram_addr, 32'd0);
                check_output("idle_ram_wdata", ram_wdata, 32'd0);
            end
            if (i_req && !exp_ig) denials = (denials < LIMIT) ? denials + 1 : LIMIT;
            else denials = 0;
        end
    end

    // Monitor: whenever an rvalid appears, pop the oldest expectation for that port.
    always @(posedge clk) begin
        #2;
        if (!rstn) begin
            check_output("reset_instr_rvalid", 32'(instr_rvalid), 32'd0);
            check_output("reset_data_rvalid", 32'(data_rvalid), 32'd0);
        end else begin
            if (instr_rvalid) begin
                total++;
                if (iq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL instr_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cycle);
                end else begin
                    logic [31:0] e;
                    e = iq.pop_front();
                    if (instr_rdata !== e) begin
                        bad++;
                        $display("[TB] FAIL instr_rdata: got %h expected %h (cycle %0d)", instr_rdata, e, cycle);
                    end
                end
                last_i = instr_rdata;
                i_cnt++;
                i_cyc = cycle;
            end else if (iq.size() != 0) begin
                total++;
                bad++;
                $display("[TB] FAIL instr_rvalid_missing: got 0 expected 1 (cycle %0d)", cycle);
                iq.delete();
            end
            if (data_rvalid) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL data_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cycle);
                end else begin
                    logic [31:0] e;
                    e = dq.pop_front();
                    if (data_rdata !== e) begin
                        bad++;
                        $display("[TB] FAIL data_rdata: got %h expected %h (cycle %0d)", data_rdata, e, cycle);
                    end
                end
                last_d = data_rdata;
                d_cnt++;
                d_cyc = cycle;
            end else if (dq.size() != 0) begin
                total++;
                bad++;
                $display("[TB] FAIL data_rvalid_missing: got 0 expected 1 (cycle %0d)", cycle);
                dq.delete();
            end
        end
    end

    task automatic hold_both(input int n, input logic [31:0] iaddr, input logic [31:0] daddr, output string log);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = iaddr;
        d_req = 1'b1; d_we = 1'b0; d_addr = daddr;
        log = "";
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (instr_gnt && data_gnt) log = {log, "X"};
            else if (instr_gnt)        log = {log, "I"};
            else if (data_gnt)         log = {log, "D"};
            else                       log = {log, "-"};
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (!(i_req && !exp_ig)) begin
                i_req  = 1'($urandom_range(0, 1));
                i_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!(d_req && !exp_dg)) begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = ($urandom_range(0, 2) == 0);
                d_be    = 4'($urandom_range(1, 15));
                d_addr  = 32'($urandom_range(0, 255)) << 2;
                d_wdata = $urandom;
            end
        end
    endtask

    initial begin
        string log;
        int    saved;
        for (int w = 0; w < 256; w++) begin
            ram_mem[w] = 32'(w) * 32'h0100_0193 + 32'h5a5a_0000;
        end
        ram_mem[0] = 32'h0050_0093;
        ram_mem[1] = 32'h1122_3344;
        ram_mem[2] = 32'h0000_0000;
        for (int w = 0; w < 256; w++) ref_mem[w] = ram_mem[w];

        // Reset with both requests high, then contention straight after release.
        rstn = 1'b0;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check_output("first_grant_data", 32'(data_gnt), 32'd1);
        log = "D";
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            log = {log, instr_gnt ? (data_gnt ? "X" : "I") : (data_gnt ? "D" : "-")};
        end
        total++;
        if (log != "DDDDIDDDDI") begin
            bad++;
            $display("[TB] FAIL contention_pattern: got %s expected DDDDIDDDDI", log);
        end
        idle(2);

        // Fetch only.
        i_req = 1'b1; i_addr = 32'h0;
        idle(2);
        check_output("fetch_rdata", last_i, 32'h0050_0093);

        // Partial write then readback; only the read returns rvalid.
        saved = d_cnt;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        d_we = 1'b0; d_be = '0;
        idle(2);
        check_output("write_readback", last_d, 32'h0000_BEEF);
        check_output("data_rvalid_count", 32'(d_cnt - saved), 32'd1);

        // Back-to-back fetch then data read.
        i_req = 1'b1; i_addr = 32'h0;
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        idle(2);
        check_output("b2b_instr_rdata", last_i, 32'h0050_0093);
        check_output("b2b_data_rdata", last_d, 32'h1122_3344);
        check_output("b2b_consecutive", 32'(d_cyc - i_cyc), 32'd1);

        // Reset the cycle after a data read grant: the response must be dropped.
        hold_both(3, 32'h20, 32'hC, log);
        total++;
        if (log != "DDD") begin
            bad++;
            $display("[TB] FAIL pre_reset_pattern: got %s expected DDD", log);
        end
        #1;
        rstn = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        iq.delete(); dq.delete();
        saved = d_cnt;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check_output("post_reset_no_rvalid", 32'(d_cnt - saved), 32'd0);
        hold_both(5, 32'h24, 32'h28, log);
        total++;
        if (log != "DDDDI") begin
            bad++;
            $display("[TB] FAIL post_reset_starve: got %s expected DDDDI", log);
        end
        idle(2);

        // Randomized traffic against the reference model.
        apply_stimulus(600);
        idle(4);
        check_output("instr_queue_drained", 32'(iq.size()), 32'd0);
        check_output("data_queue_drained", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
